// File: rtl/phv_pkg.sv
// Shared definitions for the match-action stage shell: PHV geometry and mode FSM encoding.
package phv_pkg;

   localparam int PHV_LEN    = 1579;

   // PHV field layout, LSB first
   localparam int HDR_OFF    = 0;
   localparam int HDR_LEN    = 1024;
   localparam int VLD_OFF    = 1024;
   localparam int VLD_LEN    = 7;
   localparam int KEY_OFF    = 1031;
   localparam int KEY_LEN    = 192;
   localparam int ACT_OFF    = 1223;
   localparam int ACT_LEN    = 100;
   localparam int MD_OFF     = 1323;
   localparam int MD_LEN     = 256;

   typedef enum logic [1:0] {
      MODE_RUN    = 2'd0,
      MODE_DRAIN  = 2'd1,
      MODE_SWITCH = 2'd2
   } mode_state_t;

endpackage

// File: rtl/phv_fwft_fifo.sv
// First-word-fall-through FIFO with occupancy count; simultaneous read and write are legal even when full.
module phv_fwft_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_wr_s;
   logic             do_rd_s;

   assign empty   = (count_r == '0);
   assign full    = (count_r == FULL_CNT);
   assign count   = count_r;
   assign do_rd_s = rd_en & !empty;
   assign do_wr_s = wr_en & (!full | do_rd_s);

   // storage array, no reset needed since reads of an empty FIFO are masked
   always_ff @(posedge clk) begin
      if (do_wr_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_rd_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_wr_s, do_rd_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // head presented as zero while empty so the output is clean after reset
   always_comb begin
      if (empty) begin
         rd_data = '0;
      end else begin
         rd_data = mem_r[rd_ptr_r];
      end
   end

endmodule

// File: rtl/stage_flow_shell.sv
// Flow-control shell around a fixed-latency stage pipeline: credit-based backpressure,
// output FIFO, drain-then-switch bypass mode and statistics.
module stage_flow_shell #(
   parameter int PHV_LEN = phv_pkg::PHV_LEN,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 32
) (
   input  logic                axis_clk,
   input  logic                aresetn,
   input  logic [PHV_LEN-1:0]  phv_in,
   input  logic                phv_in_valid,
   output logic                phv_in_ready,
   output logic [PHV_LEN-1:0]  pipe_phv_out,
   output logic                pipe_phv_out_valid,
   input  logic [PHV_LEN-1:0]  pipe_phv_in,
   input  logic                pipe_phv_in_valid,
   output logic [PHV_LEN-1:0]  phv_out,
   output logic                phv_out_valid,
   input  logic                phv_out_ready,
   input  logic                bypass_en,
   output logic                bypass_active,
   output logic [CNT_W-1:0]    pkt_cnt,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic                err_flag
);
   import phv_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      FLT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW+1:0]    CREDIT  = (AW+2)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   mode_state_t        state_r, state_nxt_s;
   logic [AW:0]        fifo_cnt_s;
   logic [AW:0]        in_flight_r;
   logic [AW+1:0]      credit_sum_s;
   logic               switch_pending_s, load_mode_s;
   logic               ready_s, accept_s, acc_norm_s, acc_byp_s;
   logic               pop_s, ret_cred_s, ret_ok_s, ret_err_s;
   logic               fifo_wr_s, fifo_empty_s, fifo_full_s;
   logic [PHV_LEN-1:0] fifo_wdata_s;
   logic [PHV_LEN-1:0] pipe_phv_r;
   logic               pipe_valid_r, bypass_r, err_r;
   logic [CNT_W-1:0]   pkt_cnt_r, stall_cnt_r;

   assign credit_sum_s = {1'b0, fifo_cnt_s} + {1'b0, in_flight_r};
   assign ready_s      = (credit_sum_s < CREDIT) & !switch_pending_s;
   assign accept_s     = phv_in_valid & ready_s;
   assign acc_norm_s   = accept_s & !bypass_r;
   assign acc_byp_s    = accept_s & bypass_r;
   assign pop_s        = !fifo_empty_s & phv_out_ready;
   // a return always gives its credit back; it only lands if it was expected and there is room
   assign ret_cred_s   = pipe_phv_in_valid & (in_flight_r != '0);
   assign ret_ok_s     = ret_cred_s & (!fifo_full_s | pop_s);
   assign ret_err_s    = pipe_phv_in_valid & ((in_flight_r == '0) | (fifo_full_s & !pop_s));
   assign fifo_wr_s    = ret_ok_s | acc_byp_s;

   // bypass writes never coincide with legal returns: bypass is entered only with nothing in flight
   always_comb begin
      if (ret_ok_s) begin
         fifo_wdata_s = pipe_phv_in;
      end else begin
         fifo_wdata_s = phv_in;
      end
   end

   phv_fwft_fifo #(.WIDTH(PHV_LEN), .DEPTH(DEPTH)) u_fifo (
      .clk     (axis_clk),
      .rst_n   (aresetn),
      .wr_en   (fifo_wr_s),
      .wr_data (fifo_wdata_s),
      .rd_en   (pop_s),
      .rd_data (phv_out),
      .count   (fifo_cnt_s),
      .empty   (fifo_empty_s),
      .full    (fifo_full_s)
   );

   // mode state register; reset lands in DRAIN so a mode requested across reset settles without a RUN detour
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         state_r <= MODE_DRAIN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // mode next-state
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         MODE_RUN: begin
            if (bypass_en != bypass_r) state_nxt_s = MODE_DRAIN;
            else                       state_nxt_s = MODE_RUN;
         end
         MODE_DRAIN: begin
            if (bypass_en == bypass_r)      state_nxt_s = MODE_RUN;
            else if (in_flight_r == '0)     state_nxt_s = MODE_SWITCH;
            else                            state_nxt_s = MODE_DRAIN;
         end
         MODE_SWITCH: state_nxt_s = MODE_RUN;
         default:     state_nxt_s = MODE_RUN;
      endcase
   end

   // mode outputs
   always_comb begin
      switch_pending_s = 1'b0;
      load_mode_s      = 1'b0;
      case (state_r)
         MODE_RUN:    switch_pending_s = 1'b0;
         MODE_DRAIN:  switch_pending_s = 1'b1;
         MODE_SWITCH: begin
            switch_pending_s = 1'b1;
            load_mode_s      = 1'b1;
         end
         default:     switch_pending_s = 1'b1;
      endcase
   end

   // credit, inner-pipeline launch, mode, error and statistics registers
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         in_flight_r  <= '0;
         pipe_phv_r   <= '0;
         pipe_valid_r <= 1'b0;
         bypass_r     <= 1'b0;
         err_r        <= 1'b0;
         pkt_cnt_r    <= '0;
         stall_cnt_r  <= '0;
      end else begin
         case ({acc_norm_s, ret_cred_s})
            2'b10:   in_flight_r <= in_flight_r + FLT_ONE;
            2'b01:   in_flight_r <= in_flight_r - FLT_ONE;
            default: in_flight_r <= in_flight_r;
         endcase
         pipe_valid_r <= acc_norm_s;
         if (acc_norm_s) begin
            pipe_phv_r <= phv_in;
         end
         if (load_mode_s) begin
            bypass_r <= bypass_en;
         end
         err_r <= err_r | ret_err_s;
         if (pop_s) begin
            pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
         end
         if (phv_in_valid && !ready_s && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end
      end
   end

   assign phv_in_ready       = ready_s;
   assign pipe_phv_out       = pipe_phv_r;
   assign pipe_phv_out_valid = pipe_valid_r;
   assign phv_out_valid      = !fifo_empty_s;
   assign bypass_active      = bypass_r;
   assign pkt_cnt            = pkt_cnt_r;
   assign stall_cnt          = stall_cnt_r;
   assign err_flag           = err_r;

endmodule

// File: tb/tb_stage_flow_shell.sv
// Directed bench for stage_flow_shell: inner pipeline modelled as a 4-cycle delay line,
// output order checked against a scoreboard queue filled on every accepted input.
module tb_stage_flow_shell;
   localparam int PHV_LEN = phv_pkg::PHV_LEN;

   logic               clk = 1'b0;
   logic               aresetn;
   logic [PHV_LEN-1:0] phv_in;
   logic               phv_in_valid;
   logic               phv_in_ready;
   logic [PHV_LEN-1:0] pipe_phv_out;
   logic               pipe_phv_out_valid;
   logic [PHV_LEN-1:0] pipe_phv_in;
   logic               pipe_phv_in_valid;
   logic [PHV_LEN-1:0] phv_out;
   logic               phv_out_valid;
   logic               phv_out_ready;
   logic               bypass_en;
   logic               bypass_active;
   logic [31:0]        pkt_cnt;
   logic [31:0]        stall_cnt;
   logic               err_flag;

   logic               inject;
   logic [PHV_LEN-1:0] inj_d;
   logic [PHV_LEN-1:0] dl_d [4];
   logic [3:0]         dl_v;
   logic [PHV_LEN-1:0] sb [$];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stage_flow_shell #(.PHV_LEN(PHV_LEN), .DEPTH(8), .CNT_W(32)) dut (
      .axis_clk           (clk),
      .aresetn            (aresetn),
      .phv_in             (phv_in),
      .phv_in_valid       (phv_in_valid),
      .phv_in_ready       (phv_in_ready),
      .pipe_phv_out       (pipe_phv_out),
      .pipe_phv_out_valid (pipe_phv_out_valid),
      .pipe_phv_in        (pipe_phv_in),
      .pipe_phv_in_valid  (pipe_phv_in_valid),
      .phv_out            (phv_out),
      .phv_out_valid      (phv_out_valid),
      .phv_out_ready      (phv_out_ready),
      .bypass_en          (bypass_en),
      .bypass_active      (bypass_active),
      .pkt_cnt            (pkt_cnt),
      .stall_cnt          (stall_cnt),
      .err_flag           (err_flag)
   );

   // inner pipeline model: fixed 4-cycle delay, emptied by reset
   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         dl_v <= 4'b0000;
      end else begin
         dl_v     <= {dl_v[2:0], pipe_phv_out_valid};
         dl_d[0]  <= pipe_phv_out;
         dl_d[1]  <= dl_d[0];
         dl_d[2]  <= dl_d[1];
         dl_d[3]  <= dl_d[2];
      end
   end
   assign pipe_phv_in_valid = dl_v[3] | inject;
   assign pipe_phv_in       = inject ? inj_d : dl_d[3];

   function automatic logic [PHV_LEN-1:0] mk(input int tag);
      logic [PHV_LEN-1:0] v;
      v = '0;
      v[31:0] = tag;
      v[700 +: 16] = tag[15:0] ^ 16'hA5A5;
      v[PHV_LEN-1 -: 32] = ~tag;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_phv(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed_lo=%0h expected_lo=%0h", tag, obs[63:0], exp_v[63:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pkt(input logic [31:0] n);
      int k;
      k = 0;
      while (pkt_cnt !== n && k < 200) begin
         step();
         k++;
      end
      chk("wait_pkt", pkt_cnt, n);
   endtask

   // scoreboard: push on input handshake, pop and compare on output handshake
   always @(negedge clk) begin
      logic [PHV_LEN-1:0] exp_v;
      if (aresetn === 1'b1) begin
         if (phv_in_valid && phv_in_ready) sb.push_back(phv_in);
         if (phv_out_valid && phv_out_ready) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               exp_v = sb.pop_front();
               chk_phv("sb_order", phv_out, exp_v);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_acc, nxt, k;
      logic acc;
      aresetn = 1'b0; phv_in = '0; phv_in_valid = 1'b0; phv_out_ready = 1'b0;
      bypass_en = 1'b0; inject = 1'b0; inj_d = '0;
      repeat (3) step();
      chk("rst_out_valid", phv_out_valid, 1'b0);
      chk("rst_pipe_valid", pipe_phv_out_valid, 1'b0);
      chk("rst_pkt", pkt_cnt, 32'd0);
      chk("rst_stall", stall_cnt, 32'd0);
      chk("rst_err", err_flag, 1'b0);
      chk("rst_bypass", bypass_active, 1'b0);
      chk("rst_ready", phv_in_ready, 1'b0);
      aresetn = 1'b1;
      step();
      chk("ready_after_rst", phv_in_ready, 1'b1);

      // 1: three back-to-back PHVs through the inner pipeline
      phv_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         phv_in = mk(i + 1); phv_in_valid = 1'b1;
         step();
         chk("t1_pipe_valid", pipe_phv_out_valid, 1'b1);
         chk_phv("t1_pipe_data", pipe_phv_out, mk(i + 1));
      end
      phv_in_valid = 1'b0;
      step();
      chk("t1_pipe_idle", pipe_phv_out_valid, 1'b0);
      wait_pkt(32'd3);
      chk("t1_err", err_flag, 1'b0);

      // 2: blocked output, 12 offered, credit limits acceptance to 8
      phv_out_ready = 1'b0; nxt = 10; n_acc = 0;
      phv_in = mk(nxt); phv_in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); acc = phv_in_ready;
         step();
         if (acc) begin n_acc++; nxt++; phv_in = mk(nxt); end
      end
      chk("t2_accepted", 64'(n_acc), 64'd8);
      chk("t2_ready_low", phv_in_ready, 1'b0);
      chk("t2_stall_cnt", stall_cnt, 32'd12);
      phv_out_ready = 1'b1; k = 0;
      while (n_acc < 12 && k < 100) begin
         @(negedge clk); acc = phv_in_ready;
         step();
         if (acc) begin n_acc++; nxt++; phv_in = mk(nxt); end
         if (n_acc == 12) phv_in_valid = 1'b0;
         k++;
      end
      phv_in_valid = 1'b0;
      chk("t2_all_accepted", 64'(n_acc), 64'd12);
      wait_pkt(32'd15);

      // 3: switch to bypass with two PHVs in flight
      phv_in = mk(30); phv_in_valid = 1'b1; step();
      phv_in = mk(31); step();
      phv_in_valid = 1'b0; bypass_en = 1'b1;
      step();
      k = 0;
      while (!bypass_active && k < 30) begin
         @(negedge clk);
         if (!bypass_active) chk("t3_drain_ready", phv_in_ready, 1'b0);
         step();
         k++;
      end
      chk("t3_bypass_on", bypass_active, 1'b1);
      chk("t3_pkt_before", pkt_cnt, 32'd17);
      phv_in = mk(32); phv_in_valid = 1'b1;
      @(negedge clk);
      chk("t3_byp_ready", phv_in_ready, 1'b1);
      step();
      phv_in_valid = 1'b0;
      chk("t3_byp_valid", phv_out_valid, 1'b1);
      chk_phv("t3_byp_data", phv_out, mk(32));
      wait_pkt(32'd18);
      bypass_en = 1'b0; k = 0;
      while (bypass_active && k < 10) begin step(); k++; end
      chk("t3_bypass_off", bypass_active, 1'b0);

      // 4: unexpected return with nothing in flight
      phv_out_ready = 1'b0;
      phv_in = mk(40); phv_in_valid = 1'b1; step();
      phv_in_valid = 1'b0; k = 0;
      while (!phv_out_valid && k < 20) begin step(); k++; end
      chk("t4_landed", phv_out_valid, 1'b1);
      inj_d = mk(99); inject = 1'b1; step();
      inject = 1'b0;
      chk("t4_err_set", err_flag, 1'b1);
      chk_phv("t4_head_kept", phv_out, mk(40));
      repeat (3) step();
      chk("t4_err_sticky", err_flag, 1'b1);
      phv_out_ready = 1'b1;
      wait_pkt(32'd19);
      chk("t4_single_entry", phv_out_valid, 1'b0);

      // 5: reset in the middle of a burst with 5 queued
      phv_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin phv_in = mk(50 + i); phv_in_valid = 1'b1; step(); end
      phv_in_valid = 1'b0;
      repeat (6) step();
      chk("t5_queued", phv_out_valid, 1'b1);
      phv_in = mk(55); phv_in_valid = 1'b1;
      repeat (2) step();
      aresetn = 1'b0; phv_in_valid = 1'b0;
      sb.delete();
      #1;
      chk("t5_out_valid", phv_out_valid, 1'b0);
      chk("t5_pkt", pkt_cnt, 32'd0);
      chk("t5_stall", stall_cnt, 32'd0);
      chk("t5_err", err_flag, 1'b0);
      step();
      aresetn = 1'b1;
      step();
      @(negedge clk);
      chk("t5_ready", phv_in_ready, 1'b1);
      phv_out_ready = 1'b1;
      step();
      phv_in = mk(60); phv_in_valid = 1'b1; step();
      phv_in_valid = 1'b0;
      wait_pkt(32'd1);
      repeat (8) step();
      chk("t5_no_stale", pkt_cnt, 32'd1);

      // 6: bypass requested across reset
      aresetn = 1'b0; bypass_en = 1'b1;
      repeat (2) step();
      aresetn = 1'b1;
      #1;
      chk("t6_c0_ready", phv_in_ready, 1'b0);
      chk("t6_c0_bypass", bypass_active, 1'b0);
      step();
      chk("t6_c1_ready", phv_in_ready, 1'b0);
      chk("t6_c1_bypass", bypass_active, 1'b0);
      step();
      chk("t6_c2_bypass", bypass_active, 1'b1);
      chk("t6_c2_ready", phv_in_ready, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
